// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first.
// Bytes pushed into a 2**ADDR_W deep FIFO are framed and serialised on tx_o.
// A frame is one start bit, eight data bits and STOP_BITS stop bits, each
// BIT_CYCLES = CLK_FREQ/BAUD clocks long. Transmission starts whenever the
// FIFO holds data. Queued bytes follow each other with no idle gap.
//
// Ports:
//   clk         system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   wr_en_i     push wr_data_i this cycle (dropped when full)
//   wr_data_i   byte to transmit
//   full_o      FIFO holds 2**ADDR_W entries
//   empty_o     FIFO holds no entries
//   overflow_o  one-cycle pulse after a write was dropped because full
//   busy_o      high while tx_o carries a frame
//   tx_o        registered serial line, idles high
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int ADDR_W    = 4,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CW-1:0]   CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              push;
  logic              pop;
  logic              bit_end;

  // FIFO status comes from the registered count only.
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;
  assign busy_o     = busy_q;
  assign tx_o       = tx_q;

  // A full FIFO refuses the write even if the FSM pops in the same cycle.
  assign push    = wr_en_i && !full_o;
  assign bit_end = (cyc_q == CYC_LAST);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en_i && full_o;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, bit timing and pop decisions.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_o) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cyc_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (!empty_o) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy are registered, so both trail the state by one
  // clock and stay aligned with each other for the whole frame.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_q)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = shift_q[0];
      default: tx_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two DUT copies (one and two stop bits, BIT_CYCLES=10,
// depth 4) checked every cycle against a frame-timing model, plus literal
// expectations for the directed scenarios.
module tb_uart_tx_fifo;

  localparam int BC    = 10;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] wen   = 2'b00;
  logic [7:0] wdat [2];
  logic [1:0] full_w, empty_w, ovf_w, busy_w, tx_w;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(100), .BAUD(10), .ADDR_W(2), .STOP_BITS(1)) u_sb1 (
    .clk(clk), .rst_ni(rst_n), .wr_en_i(wen[0]), .wr_data_i(wdat[0]),
    .full_o(full_w[0]), .empty_o(empty_w[0]), .overflow_o(ovf_w[0]),
    .busy_o(busy_w[0]), .tx_o(tx_w[0]));

  uart_tx_fifo #(.CLK_FREQ(100), .BAUD(10), .ADDR_W(2), .STOP_BITS(2)) u_sb2 (
    .clk(clk), .rst_ni(rst_n), .wr_en_i(wen[1]), .wr_data_i(wdat[1]),
    .full_o(full_w[1]), .empty_o(empty_w[1]), .overflow_o(ovf_w[1]),
    .busy_o(busy_w[1]), .tx_o(tx_w[1]));

  // Reference model: a byte queue plus "cycles since the frame started".
  logic [7:0] mq [2][DEPTH];
  int         mhead [2];
  int         mcnt  [2];
  int         mt    [2];
  bit         mact  [2];
  logic [7:0] mcur  [2];
  logic       e_tx  [2];
  logic       e_busy[2];
  logic       e_ovf [2];

  function automatic logic line_level(input int t, input logic [7:0] b);
    int n;
    n = t / BC;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int fl;
    bit pre_full, pre_empty, pop;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mhead[k] = 0; mcnt[k] = 0; mt[k] = 0; mact[k] = 1'b0;
        e_tx[k] = 1'b1; e_busy[k] = 1'b0; e_ovf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        fl        = (9 + k + 1) * BC;
        pre_full  = (mcnt[k] == DEPTH);
        pre_empty = (mcnt[k] == 0);
        e_tx[k]   = mact[k] ? line_level(mt[k], mcur[k]) : 1'b1;
        e_busy[k] = mact[k];
        pop       = 1'b0;
        if (!mact[k]) begin
          if (!pre_empty) begin pop = 1'b1; mact[k] = 1'b1; mt[k] = 0; end
        end else if (mt[k] == fl - 1) begin
          if (!pre_empty) begin pop = 1'b1; mt[k] = 0; end
          else mact[k] = 1'b0;
        end else begin
          mt[k] = mt[k] + 1;
        end
        if (pop) begin
          mcur[k]  = mq[k][mhead[k]];
          mhead[k] = (mhead[k] + 1) % DEPTH;
          mcnt[k]  = mcnt[k] - 1;
        end
        e_ovf[k] = wen[k] && pre_full;
        if (wen[k] && !pre_full) begin
          mq[k][(mhead[k] + mcnt[k]) % DEPTH] = wdat[k];
          mcnt[k] = mcnt[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h time=%0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("tx", k, tx_w[k], e_tx[k]);
        chk("busy", k, busy_w[k], e_busy[k]);
        chk("overflow", k, ovf_w[k], e_ovf[k]);
        chk("empty", k, empty_w[k], mcnt[k] == 0);
        chk("full", k, full_w[k], mcnt[k] == DEPTH);
      end
    end
  end

  logic s_tx [400];
  logic s_busy [400];
  logic s_empty [400];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic capture(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      s_tx[j] = tx_w[k]; s_busy[j] = busy_w[k]; s_empty[j] = empty_w[k];
      step();
    end
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = s_tx[base + BC * (i + 1) + 5];
    return b;
  endfunction

  function automatic int busy_count(input int n);
    int c;
    c = 0;
    for (int j = 0; j < n; j++) if (s_busy[j]) c++;
    return c;
  endfunction

  function automatic int first_low(input int n);
    for (int j = 0; j < n; j++) if (!s_tx[j]) return j;
    return -1;
  endfunction

  task automatic do_reset();
    step(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  task automatic write_one(input int k, input logic [7:0] d);
    wen[k] = 1'b1; wdat[k] = d; step(); wen[k] = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ovf_seen;
    bit found;
    int lows;
    wdat[0] = 8'h00; wdat[1] = 8'h00;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_tx", 0, tx_w[0], 1'b1);
    chk("reset_empty", 0, empty_w[0], 1'b1);
    chk("reset_full", 0, full_w[0], 1'b0);
    chk("reset_busy", 1, busy_w[1], 1'b0);
    step(); step(); rst_n = 1'b1;
    step(); step();

    // Single byte from idle.
    write_one(0, 8'hA5);
    capture(0, 120);
    chk("t1_first_low", 0, first_low(120), 2);
    chk("t1_busy_len", 0, busy_count(120), 100);
    chk("t1_byte", 0, decode(2), 8'hA5);
    chk("t1_start_mid", 0, s_tx[7], 1'b0);
    chk("t1_stop_mid", 0, s_tx[97], 1'b1);
    chk("t1_after", 0, {s_tx[102], s_busy[102]}, 2'b10);

    // Three back-to-back frames.
    wen[0] = 1'b1; wdat[0] = 8'h00; step();
    wdat[0] = 8'hFF; step();
    wdat[0] = 8'h55; step();
    wen[0] = 1'b0;
    capture(0, 320);
    chk("t2_busy_len", 0, busy_count(320), 300);
    chk("t2_busy_edges", 0, {s_busy[0], s_busy[299], s_busy[300]}, 3'b110);
    chk("t2_empty_pre", 0, s_empty[198], 1'b0);
    chk("t2_empty_post", 0, s_empty[199], 1'b1);

    // Five writes from reset, then overflow on a full FIFO.
    do_reset();
    step();
    ovf_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wen[0] = 1'b1; wdat[0] = 8'h10 + 8'(i); step();
      ovf_seen = ovf_seen | ovf_w[0];
    end
    wen[0] = 1'b0;
    chk("t3_no_ovf", 0, ovf_seen, 1'b0);
    chk("t3_full", 0, full_w[0], 1'b1);
    write_one(0, 8'h77);
    chk("t3_ovf_pulse", 0, ovf_w[0], 1'b1);
    step();
    chk("t3_ovf_clear", 0, ovf_w[0], 1'b0);
    chk("t3_still_full", 0, full_w[0], 1'b1);
    repeat (600) step();
    chk("t3_drained", 0, {empty_w[0], busy_w[0]}, 2'b10);

    // Write on the exact cycle a full FIFO is popped.
    write_one(0, 8'hC3);
    repeat (20) step();
    for (int i = 0; i < 4; i++) begin
      wen[0] = 1'b1; wdat[0] = 8'hE0 + 8'(i); step();
    end
    wen[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (mact[0] && mt[0] == 10 * BC - 1 && mcnt[0] == DEPTH) found = 1'b1;
      else step();
    end
    chk("t5_pop_window", 0, found, 1'b1);
    write_one(0, 8'h99);
    chk("t5_ovf", 0, ovf_w[0], 1'b1);
    chk("t5_not_full", 0, {full_w[0], empty_w[0]}, 2'b00);
    repeat (600) step();

    // Two stop bits.
    write_one(1, 8'h81);
    capture(1, 130);
    chk("t6_busy_len", 1, busy_count(130), 110);
    chk("t6_byte", 1, decode(2), 8'h81);
    chk("t6_stop", 1, {s_tx[97], s_tx[107], s_tx[111]}, 3'b111);
    chk("t6_after", 1, s_busy[112], 1'b0);

    // Reset in the middle of a frame.
    write_one(0, 8'h3C);
    write_one(0, 8'h11);
    repeat (15) step();
    chk("t4_pre_bit0", 0, tx_w[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_tx", 0, tx_w[0], 1'b1);
    chk("t4_busy", 0, busy_w[0], 1'b0);
    chk("t4_empty", 0, empty_w[0], 1'b1);
    step(); step(); rst_n = 1'b1;
    capture(0, 200);
    lows = 0;
    for (int j = 0; j < 200; j++) if (!s_tx[j]) lows++;
    chk("t4_quiet", 0, lows, 0);

    // Randomised traffic on both copies.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        wen[k]  = ($urandom_range(0, 99) < ((c < 1500) ? 40 : (c < 3000) ? 5 : 60));
        wdat[k] = 8'($urandom);
      end
      step();
    end
    wen = 2'b00;
    repeat (1500) step();
    chk("rand_drain", 0, empty_w[0], 1'b1);
    chk("rand_drain", 1, empty_w[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
